// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int ITER_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FINISH,
        ST_DIVZ
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_sel_e;

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the main control and the multiply/divide unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             hilo_write;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, start_div, op_a, op_b,
        input  busy, done, hilo_write, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
        output busy, done, hilo_write, div_zero, hi, lo
    );
endinterface

// File: rtl/multdiv_core.sv
// Iterative datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
module multdiv_core
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load_i,
    input  op_sel_e          load_op_i,
    input  logic             step_i,
    input  op_sel_e          step_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o
);

    // upper: accumulator / partial remainder; lower: multiplier / dividend-then-quotient
    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    always_comb begin
        addend    = lower_q[0] ? opnd_q : '0;
        add_sum   = {1'b0, upper_q} + {1'b0, addend};
        rem_shift = {upper_q, lower_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opnd_q});
        // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
        rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        opnd_d    = opnd_q;
        if (load_i) begin
            upper_d = '0;
            opnd_d  = (load_op_i == OP_MULT) ? a_i : b_i;
            lower_d = (load_op_i == OP_MULT) ? b_i : a_i;
        end else if (step_i) begin
            if (step_op_i == OP_MULT) begin
                upper_d = add_sum[WIDTH:1];
                lower_d = {add_sum[0], lower_q[WIDTH-1:1]};
            end else begin
                upper_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                lower_d = {lower_q[WIDTH-2:0], rem_ge};
            end
        end
    end

    always_ff @(posedge clk) begin
        upper_q <= upper_d;
        lower_q <= lower_d;
        opnd_q  <= opnd_d;
    end

    assign hi_nxt_o = upper_d;
    assign lo_nxt_o = lower_d;

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide controller: FSM, iteration counter, handshake and HI/LO registers.
// Define MULTDIV_SIGNED_EN for two's-complement operands (magnitude datapath plus sign fix-up).
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    multdiv_if.slave bus
);

    state_e                  state_q, state_d;
    logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;
    logic [WIDTH-1:0]        a_mag, b_mag;
    logic [WIDTH-1:0]        core_hi, core_lo;
    logic                    accept, iterating, last_iter, commit;
    op_sel_e                 load_op, step_op;

    assign accept    = (state_q == ST_IDLE) && (bus.start_mult || bus.start_div);
    assign iterating = (state_q == ST_MULT) || (state_q == ST_DIV);
    assign last_iter = (cnt_q == ITER_CNT_W'(WIDTH - 1));
    assign commit    = iterating && last_iter;
    assign load_op   = bus.start_mult ? OP_MULT : OP_DIV;
    assign step_op   = (state_q == ST_DIV) ? OP_DIV : OP_MULT;

`ifdef MULTDIV_SIGNED_EN
    logic                  neg_p_q, neg_r_q;
    logic [2*WIDTH-1:0]    prod_fix;

    assign a_mag    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign b_mag    = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    assign prod_fix = neg_p_q ? -{core_hi, core_lo} : {core_hi, core_lo};

    // Product and quotient take the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_p_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_r_q <= bus.op_a[WIDTH-1];
        end
    end

    always_comb begin
        if (state_q == ST_MULT) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else begin
            hi_d = neg_r_q ? -core_hi : core_hi;
            lo_d = neg_p_q ? -core_lo : core_lo;
        end
    end
`else
    assign a_mag = bus.op_a;
    assign b_mag = bus.op_b;
    assign hi_d  = core_hi;
    assign lo_d  = core_lo;
`endif

    multdiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .load_i    (accept),
        .load_op_i (load_op),
        .step_i    (iterating),
        .step_op_i (step_op),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .hi_nxt_o  (core_hi),
        .lo_nxt_o  (core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_mult) begin
                    state_d = ST_MULT;
                end else if (bus.start_div) begin
                    state_d = (bus.op_b == '0) ? ST_DIVZ : ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (last_iter) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH, ST_DIVZ: state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = iterating;
        bus.done       = (state_q == ST_FINISH) || (state_q == ST_DIVZ);
        bus.hilo_write = (state_q == ST_FINISH);
        bus.div_zero   = (state_q == ST_DIVZ);
    end

    assign cnt_d = accept ? '0 : (iterating ? cnt_q + 1'b1 : cnt_q);

    // Result lands on the last iteration edge so it is visible alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (commit) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed table, corner sequences, randomized ops vs. model.
`timescale 1ns/1ps
module tb_multdiv_ctrl;

    localparam int W = 32;
`ifdef MULTDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    multdiv_if #(.WIDTH(W)) bus ();

    multdiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers; returns {hi, lo}.
    function automatic logic [63:0] ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        if (SGN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (is_mult) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    typedef struct {
        string       name;
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          elat;
        bit          ehw;
        bit          edz;
    } vec_t;

    vec_t vt[$];

    function automatic void add_vec(input string nm, input bit m, input bit d,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ehi, input logic [31:0] elo,
                                    input int elat, input bit ehw, input bit edz);
        vec_t v;
        v.name = nm; v.m = m; v.d = d; v.a = a; v.b = b;
        v.ehi = ehi; v.elo = elo; v.elat = elat; v.ehw = ehw; v.edz = edz;
        vt.push_back(v);
    endfunction

    // Issue one start in the current (idle) cycle, wait for done, then step into the following idle cycle.
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                         output bit rhw, output bit rdz, output bit held, output bit bsy_done);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
        lat = -1; rhi = '0; rlo = '0; rhw = 1'b0; rdz = 1'b0; held = 1'b1; bsy_done = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                lat = k; rhi = bus.hi; rlo = bus.lo;
                rhw = bus.hilo_write; rdz = bus.div_zero; bsy_done = bus.busy;
                break;
            end
            if (!bus.busy || bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, ndone, first, nbusy;
        logic [31:0] rhi, rlo, got_lo, mhi, mlo, a, b;
        logic [63:0] exp;
        bit          rhw, rdz, held, bsy, m, d, is_mult, is_dz;

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        reset          = 1'b1;

        add_vec("mul_7x6",   1, 0, 32'd7,        32'd6,        32'd0,        32'd42,       33, 1, 0);
        add_vec("div_100_7", 0, 1, 32'd100,      32'd7,        32'd2,        32'd14,       33, 1, 0);
        add_vec("both_3_5",  1, 1, 32'd3,        32'd5,        32'd0,        32'd15,       33, 1, 0);
        add_vec("mul_neg1x2", 1, 0, 32'hFFFF_FFFF, 32'd2,
                SGN ? 32'hFFFF_FFFF : 32'd1, 32'hFFFF_FFFE, 33, 1, 0);
        add_vec("div_m100_7", 0, 1, 32'hFFFF_FF9C, 32'd7,
                SGN ? 32'hFFFF_FFFE : 32'd2, SGN ? 32'hFFFF_FFF2 : 32'h2492_4916, 33, 1, 0);
        add_vec("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF,
                SGN ? 32'd0 : 32'h8000_0000, SGN ? 32'h8000_0000 : 32'd0, 33, 1, 0);
        add_vec("div_zero",  0, 1, 32'd55,       32'd0,
                SGN ? 32'd0 : 32'h8000_0000, SGN ? 32'h8000_0000 : 32'd0, 1, 0, 1);
        add_vec("mul_max",   1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                SGN ? 32'd0 : 32'hFFFF_FFFE, 32'd1, 33, 1, 0);
        add_vec("div_5_9",   0, 1, 32'd5,        32'd9,        32'd5,        32'd0,        33, 1, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo_write", 64'(bus.hilo_write), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;

        // Directed table, issued back to back
        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i].m, vt[i].d, vt[i].a, vt[i].b, lat, rhi, rlo, rhw, rdz, held, bsy);
            chk({vt[i].name, "_latency"}, 64'(lat), 64'(vt[i].elat));
            chk({vt[i].name, "_hi"}, 64'(rhi), 64'(vt[i].ehi));
            chk({vt[i].name, "_lo"}, 64'(rlo), 64'(vt[i].elo));
            chk({vt[i].name, "_hilo_write"}, 64'(rhw), 64'(vt[i].ehw));
            chk({vt[i].name, "_div_zero"}, 64'(rdz), 64'(vt[i].edz));
            chk({vt[i].name, "_busy_and_hold"}, 64'(held), 64'd1);
            chk({vt[i].name, "_busy_at_done"}, 64'(bsy), 64'd0);
        end

        // start_div pulsed mid-multiply must be ignored
        bus.start_mult = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        ndone = 0; first = -1; got_lo = '0;
        for (int k = 1; k <= 45; k++) begin
            bus.start_div = (k == 5);
            if (k == 5) bus.op_b = 32'd0;
            if (bus.done) begin
                ndone++;
                if (first < 0) begin
                    first  = k;
                    got_lo = bus.lo;
                end
            end
            @(posedge clk); #1;
        end
        bus.start_div = 1'b0;
        chk("busy_start_done_count", 64'(ndone), 64'd1);
        chk("busy_start_latency", 64'(first), 64'd33);
        chk("busy_start_lo", 64'(got_lo), 64'd81);

        // Reset at iteration 10, with a start held alongside it
        bus.start_mult = 1'b1; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.start_mult = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start_mult = 1'b0;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_hi", 64'(bus.hi), 64'd0);
        chk("midreset_lo", 64'(bus.lo), 64'd0);
        ndone = 0; nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) ndone++;
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
        end
        chk("midreset_no_done", 64'(ndone), 64'd0);
        chk("midreset_no_busy", 64'(nbusy), 64'd0);

        // Randomized operations against the model
        mhi = '0;
        mlo = '0;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       begin m = 1'b1; d = 1'b0; end
                1:       begin m = 1'b0; d = 1'b1; end
                2:       begin m = 1'b1; d = 1'b1; end
                default: begin m = 1'b0; d = 1'b1; end
            endcase
            a = rnd_op();
            b = rnd_op();
            if (!m && $urandom_range(0, 5) == 0) b = '0;
            is_mult = m;
            is_dz   = !m && (b == '0);
            if (!is_dz) begin
                exp = ref_op(is_mult, a, b);
                mhi = exp[63:32];
                mlo = exp[31:0];
            end
            do_op(m, d, a, b, lat, rhi, rlo, rhw, rdz, held, bsy);
            chk("rand_latency", 64'(lat), is_dz ? 64'd1 : 64'd33);
            chk("rand_hi", 64'(rhi), 64'(mhi));
            chk("rand_lo", 64'(rlo), 64'(mlo));
            chk("rand_flags", {62'd0, rhw, rdz}, is_dz ? 64'd1 : 64'd2);
            chk("rand_busy_and_hold", 64'(held), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
